// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// operation encoding, FSM state encoding and the default operand width.
package ex_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] MULDIV_OP_MUL  = 2'd0;
    localparam logic [1:0] MULDIV_OP_DIVU = 2'd1;
    localparam logic [1:0] MULDIV_OP_REMU = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Encoding 3 is reserved and executes as MUL, so only 1 and 2 divide.
    function automatic logic op_is_div(input logic [1:0] o);
        return (o == MULDIV_OP_DIVU) || (o == MULDIV_OP_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Shared shift/add-subtract datapath for the multiply/divide sequencer.
// Register roles:
//   MUL: a = multiplicand (shifts left), b = multiplier (shifts right),
//        acc = running product.
//   DIV: a = dividend shifting out / quotient shifting in, b = divisor,
//        acc = partial remainder.
// The result register is written only on completion so it holds the last
// finished value across aborted operations.
module ex_muldiv_datapath
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic            cap_run,
    input  logic            cap_dz,
    input  logic            rem_sel,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            mul_last,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] a, b, acc;
    logic [XLEN-1:0] mul_sum, a_mul, b_mul;
    logic [XLEN:0]   shifted, diff;
    logic            borrow;
    logic [XLEN-1:0] rem_nxt, quo_nxt;
    logic [XLEN-1:0] a_nxt, b_nxt, acc_nxt;

    // One iteration of either algorithm, selected by the FSM mode.
    always_comb begin
        mul_sum = acc + (b[0] ? a : '0);
        a_mul   = a << 1;
        b_mul   = b >> 1;

        // Shifted remainder can reach XLEN+1 bits before the trial subtract.
        shifted = {acc, a[XLEN-1]};
        diff    = shifted - {1'b0, b};
        borrow  = diff[XLEN];
        rem_nxt = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_nxt = {a[XLEN-2:0], ~borrow};

        acc_nxt = div_mode ? rem_nxt : mul_sum;
        a_nxt   = div_mode ? quo_nxt : a_mul;
        b_nxt   = div_mode ? b       : b_mul;
    end

    // Multiplier exhausted after this step: no further additions can occur.
    assign mul_last = (b_mul == '0);

    // Operand/accumulator registers and the completion result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            if (load) begin
                a   <= op1;
                b   <= op2;
                acc <= '0;
            end else if (step) begin
                a   <= a_nxt;
                b   <= b_nxt;
                acc <= acc_nxt;
            end

            if (cap_dz) begin
                result <= rem_sel ? op1 : '1;
            end else if (cap_run) begin
                result <= div_mode ? (rem_sel ? rem_nxt : quo_nxt) : mul_sum;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer for the EX stage. Stalls the pipeline
// while iterating and reports completion in a one-cycle done slot.
// Optional build macro: EX_MULDIV_EARLY_OUT_EN -- finish MUL as soon as the
// remaining multiplier is zero instead of always running XLEN iterations.
module ex_muldiv_seq
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      done_rd
);

`ifdef EX_MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [4:0]       rd_q;

    logic load, step, cap_run, cap_dz;
    logic div_mode, rem_sel, mul_last;
    logic last_iter, mul_fin, accept;

    assign accept    = start && !flush;
    assign last_iter = (cnt == CNT_W'(XLEN - 1));
    assign mul_fin   = last_iter || (EARLY_OUT && mul_last);
    assign div_mode  = (state == ST_DIV);
    // Divide-by-zero resolves from IDLE, before op_q is loaded.
    assign rem_sel   = (state == ST_IDLE) ? (op == MULDIV_OP_REMU)
                                          : (op_q == MULDIV_OP_REMU);

    assign busy = (state == ST_MUL) || (state == ST_DIV) ||
                  ((state == ST_IDLE) && accept);
    assign done = (state == ST_DONE);

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        cap_run   = 1'b0;
        cap_dz    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (op_is_div(op)) begin
                        if (op2 == '0) begin
                            cap_dz    = 1'b1;
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_DIV;
                        end
                    end else begin
                        state_nxt = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (mul_fin) begin
                        cap_run   = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (last_iter) begin
                        cap_run   = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, iteration counter, latched op/rd and completion rd.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_q    <= MULDIV_OP_MUL;
            rd_q    <= '0;
            done_rd <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt  <= '0;
                op_q <= op;
                rd_q <= rd;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end

            if (cap_dz) begin
                done_rd <= rd;
            end else if (cap_run) begin
                done_rd <= rd_q;
            end
        end
    end

    ex_muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .div_mode (div_mode),
        .cap_run  (cap_run),
        .cap_dz   (cap_dz),
        .rem_sel  (rem_sel),
        .op1      (op1),
        .op2      (op2),
        .mul_last (mul_last),
        .result   (result)
    );

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: transaction-level reference model
// compared every cycle, directed cases with literal expectations, then
// randomized ops with occasional flushes.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  done_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    ex_muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op1(op1),
        .op2(op2), .rd(rd), .flush(flush), .busy(busy), .done(done),
        .result(result), .done_rd(done_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (o)
            2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: return (b == 0) ? a : a % b;
            default: begin
                p = {32'd0, a} * {32'd0, b};
                return p[31:0];
            end
        endcase
    endfunction

    // Number of cycles spent iterating (after the start cycle).
    function automatic int model_iters(input logic [1:0] o, input logic [31:0] b);
        int m;
`ifdef EX_MULDIV_EARLY_OUT_EN
        if (o == 2'd0 || o == 2'd3) begin
            m = 0;
            for (int i = 0; i < 32; i++) if (b[i]) m = i;
            return m + 1;
        end
`endif
        m = 32;
        if (o == 2'd1 && b == 0) m = 32;
        return m;
    endfunction

    logic        m_act = 1'b0, m_done = 1'b0, chk_en = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res = '0, m_out = '0;
    logic [4:0]  m_rd = '0, m_rdo = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act <= 1'b0; m_done <= 1'b0; m_left <= 0;
            m_out <= '0;   m_rdo <= '0;    chk_en <= 1'b1;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_act) begin
            if (flush) begin
                m_act <= 1'b0;
            end else if (m_left == 1) begin
                m_act <= 1'b0; m_done <= 1'b1; m_out <= m_res; m_rdo <= m_rd;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start && !flush) begin
            m_res <= model_res(op, op1, op2);
            m_rd  <= rd;
            if ((op == 2'd1 || op == 2'd2) && op2 == 0) begin
                m_done <= 1'b1; m_out <= model_res(op, op1, op2); m_rdo <= rd;
            end else begin
                m_act <= 1'b1; m_left <= model_iters(op, op2);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_act || (!m_done && start && !flush)});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("result", result, m_out);
            chk("done_rd", {27'd0, done_rd}, {27'd0, m_rdo});
        end
    end

    // ---------------- stimulus ----------------
    // Issue one op, holding start high as a stalled ID/EX would, until done,
    // or until the cycle at which flush is asserted (flush_at >= 0).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input int flush_at, output int lat);
        start = 1'b1; op = o; op1 = a; op2 = b; rd = r;
        flush = (flush_at == 0);
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done) begin lat = n; break; end
            if (flush_at >= 0 && n == flush_at) break;
            @(posedge clk); #1;
            if (flush_at > 0 && n + 1 == flush_at) begin flush = 1'b1; start = 1'b0; end
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        if (flush_at < 0 && lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: op %0d never completed", o);
        end
    endtask

    int lat, dcnt;
    int exp_lat76, exp_lat_ff2, exp_lat1000;
    logic [31:0] ra, rb;

    initial begin
`ifdef EX_MULDIV_EARLY_OUT_EN
        exp_lat76 = 4; exp_lat_ff2 = 3; exp_lat1000 = 3;
`else
        exp_lat76 = 33; exp_lat_ff2 = 33; exp_lat1000 = 33;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_done_rd", {27'd0, done_rd}, 32'd0);
        @(posedge clk); #1;

        run_op(2'd0, 32'd7, 32'd6, 5'd5, -1, lat);
        chk("mul7x6_lat", lat, exp_lat76);
        chk("mul7x6_res", result, 32'd42);
        chk("mul7x6_rd", {27'd0, done_rd}, 32'd5);
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 5'd1, -1, lat);
        chk("mulff_lat", lat, exp_lat_ff2);
        chk("mulff_res", result, 32'hFFFF_FFFE);
        run_op(2'd1, 32'd100, 32'd7, 5'd2, -1, lat);
        chk("divu_lat", lat, 33);
        chk("divu_res", result, 32'd14);
        run_op(2'd2, 32'd100, 32'd7, 5'd3, -1, lat);
        chk("remu_lat", lat, 33);
        chk("remu_res", result, 32'd2);
        run_op(2'd1, 32'd9, 32'd0, 5'd4, -1, lat);
        chk("divz_lat", lat, 1);
        chk("divz_res", result, 32'hFFFF_FFFF);
        run_op(2'd2, 32'd9, 32'd0, 5'd6, -1, lat);
        chk("remz_res", result, 32'd9);
        chk("remz_rd", {27'd0, done_rd}, 32'd6);

        // Abort a long MUL 10 cycles in; nothing may complete.
        dcnt = done_cnt;
        run_op(2'd0, 32'h1234, 32'h8000_0001, 5'd7, 10, lat);
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_nodone", done_cnt, dcnt);
        chk("flush_result", result, 32'd9);
        @(posedge clk); #1;
        run_op(2'd3, 32'd3, 32'd5, 5'd8, -1, lat);
        chk("after_flush_res", result, 32'd15);
        run_op(2'd0, 32'd1000, 32'd3, 5'd9, -1, lat);
        chk("mul1000x3_lat", lat, exp_lat1000);
        chk("mul1000x3_res", result, 32'd3000);

        // Reset in the middle of a divide.
        start = 1'b1; op = 2'd1; op1 = 32'd1000; op2 = 32'd3; rd = 5'd10;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0; start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(posedge clk); #1;

        // Randomized ops with occasional flushes.
        for (int i = 0; i < 120; i++) begin
            int sel, fl;
            ra = $urandom;
            sel = $urandom_range(0, 3);
            rb = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
            sel = $urandom_range(0, 9);
            fl = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 40) : -1;
            run_op(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)), fl, lat);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EX stage. It extends the single-cycle ALU with MUL, DIVU and REMU, executed over multiple cycles on a shared shift/add-subtract datapath.
- Accepts an operation from EX with forwarded operands already resolved.
- Drives a stall into the pipeline while it iterates.
- Returns the result and destination register in a one-cycle completion slot.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  EX presents a mul/div op this cycle.
- op  in  2  0=MUL (low XLEN bits of product), 1=DIVU, 2=REMU, 3=reserved (treated as MUL).
- op1  in  XLEN  rs1 operand, post-forwarding.
- op2  in  XLEN  rs2 operand, post-forwarding.
- rd  in  5  destination register of the op.
- flush  in  1  pipeline flush (branch/jump); aborts the op in flight.
- busy  out  1  stall request to the hazard logic (OR'd into the EX stall).
- done  out  1  one-cycle pulse; result and done_rd valid.
- result  out  XLEN  MUL product low word, quotient or remainder.
- done_rd  out  5  rd captured at start.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; counter=0.
  - done=0, result=0, done_rd=0; internal accumulator/operand registers cleared.
  - busy is combinational from state and inputs (below); it therefore reads 0 during reset.
  - Reset wins over any start or flush in the same cycle.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On start && !flush: latch op, op1, op2, rd; counter=0.
  - Go to MUL if op is 0 or 3; go to DIV if op is 1 or 2.
  - Divide by zero (op2==0): skip DIV and go straight to DONE. Result is 32'hFFFFFFFF for DIVU and op1 for REMU.
- MUL (radix-2 shift-add):
  - Each cycle, if multiplier LSB is 1, add multiplicand to the accumulator.
  - Shift multiplicand left and multiplier right; counter++.
  - After XLEN iterations go to DONE. Product is truncated to XLEN bits.
- DIV (restoring, unsigned):
  - Each cycle shift {rem,quot} left by 1.
  - Trial-subtract divisor; if no borrow, keep the difference and set quotient LSB to 1.
  - After XLEN iterations go to DONE.
- DONE:
  - done=1 for exactly this cycle; result/done_rd hold the final values.
  - Next state is IDLE.
  - done=0 in every other state.
- Latency (worst case): start in cycle N; busy high in N..N+XLEN; DONE and done in cycle N+XLEN+1, busy=0 in that cycle.
- busy = (state==MUL || state==DIV) || (state==IDLE && start && !flush). The stall is therefore asserted in the same cycle as start, holding the op in ID/EX.
- While busy, the stalled ID/EX keeps start high. start is ignored in MUL, DIV and DONE; no re-issue.
- flush:
  - In MUL or DIV: next state is IDLE; no done; result not updated.
  - In IDLE with start: start is ignored.
  - In DONE: done still pulses (the op completed before the flush).
- result and done_rd hold their value after DONE until the next completion.
- Counter wraps are impossible: the counter resets on every start.

Optional Feature:
- EX_MULDIV_EARLY_OUT_EN
  - Defined: in MUL, when the remaining multiplier is 0, go to DONE on the next edge. Latency becomes 2 + (index of highest set bit of op2), minimum 2 cycles for op2 of 0 or 1. DIV is unchanged.
  - Undefined: fixed XLEN-iteration MUL latency as specified above.

Decomposition:
- Shared package ex_muldiv_pkg:
  - op encoding constants MULDIV_OP_MUL/DIVU/REMU.
  - state encoding constants.
  - default XLEN.
- Sub-module ex_muldiv_datapath: the accumulator/shift/add-subtract registers, controlled by step, load and mode signals from the FSM.
- The FSM and counter stay in ex_muldiv_seq.

Test Plan:
- MUL 7×6, rd=5 → busy 33 cycles, done at cycle 33 after start, result=42, done_rd=5. MUL 32'hFFFFFFFF×2 → 32'hFFFFFFFE.
- DIVU 100/7 → result=14; REMU 100/7 → result=2; both complete at start+33.
- DIVU 9/0 → done at start+1, result=32'hFFFFFFFF, busy high only in the start cycle. REMU 9/0 → result=9.
- flush asserted 10 cycles into MUL → busy=0 next cycle, done never pulses, result keeps its prior value. A new start then completes normally.
- start held high during busy and in the DONE cycle → exactly one done pulse. rst_n=0 mid-DIV → next cycle state IDLE, busy=0, done=0, result=0.
- EX_MULDIV_EARLY_OUT_EN defined, MUL 1000×3 → done at start+3, result=3000.
